// File: rtl/cfa_rb_interp_pipe.sv
// ---------------------------------------------------------------------------
// cfa_rb_interp_pipe
//   Estimates the missing R or B value at a green site of the CFA demosaicer.
//   The horizontal and vertical colour differences (green - R/B) are each
//   weighted by a scaled gradient. The weighted differences are combined
//   according to a per-sample direction mode and subtracted from green. The
//   result is clamped to [0, MAX_VAL].
//
//   Pipeline: S1 multiply, S2 combine, S3 subtract/clamp into the output
//   register. Latency is 3 cycles and throughput is 1 sample/cycle. A single
//   stall term (out_valid && !out_ready) freezes every stage.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   green               unsigned green at the current site
//   scaled_h/scaled_v   unsigned gradient weights
//   diff_h/diff_v       signed colour differences (PIX_W+2)
//   mode                00 mean, 01 horiz, 10 vert, 11 dominant weight
//   out_valid/out_ready output handshake
//   rb_out, sat_flag    clamped estimate, clamp indicator
//   sat_count, sat_clr  only when CFA_SAT_COUNT_EN is defined: saturating
//                       count of transferred clamped outputs, and its clear
// ---------------------------------------------------------------------------
module cfa_rb_interp_pipe #(
   parameter int PIX_W   = 12,
   parameter int GRAD_W  = 8,
   parameter int FRAC_W  = 0,
   parameter int MAX_VAL = (1 << PIX_W) - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PIX_W-1:0]           green,
   input  logic [GRAD_W-1:0]          scaled_h,
   input  logic [GRAD_W-1:0]          scaled_v,
   input  logic signed [PIX_W+1:0]    diff_h,
   input  logic signed [PIX_W+1:0]    diff_v,
   input  logic [1:0]                 mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PIX_W-1:0]           rb_out,
   output logic                       sat_flag
`ifdef CFA_SAT_COUNT_EN
   ,
   output logic [15:0]                sat_count,
   input  logic                       sat_clr
`endif
);

   localparam int PW     = PIX_W + 2 + GRAD_W;
   localparam int STAGES = 3;
   localparam logic signed [PW+1:0] MAX_D = (PW+2)'(MAX_VAL);

   logic stall, adv;
   logic [STAGES:1] vld_pipe;

   assign stall     = out_valid && !out_ready;
   assign adv       = !stall;
   assign in_ready  = !stall;
   assign out_valid = vld_pipe[STAGES];

   // ---- S1: per-direction weighted difference (index 0 = h, 1 = v) ----
   logic [1:0][GRAD_W-1:0]  wt;
   logic [1:0][PIX_W+1:0]   dif;
   logic [1:0][PW-1:0]      p_nxt;

   assign wt  = {scaled_v, scaled_h};
   assign dif = {diff_v, diff_h};

   for (genvar d = 0; d < 2; d++) begin : g_dir
      logic signed [PW-1:0] w_ext, d_ext, prod;
      // The weight is unsigned, so it is zero-extended before the signed
      // multiply. The product magnitude always fits in PW signed bits.
      assign w_ext = $signed({{(PW-GRAD_W){1'b0}}, wt[d]});
      assign d_ext = $signed({{GRAD_W{dif[d][PIX_W+1]}}, dif[d]});
      assign prod  = (w_ext * d_ext) >>> FRAC_W;
      assign p_nxt[d] = prod;
   end

   logic [1:0][PW-1:0] p1;
   logic [PIX_W-1:0]   green1;
   logic [1:0]         mode1;
   logic               h_gt1, v_gt1;

   // ---- S2: combine according to mode ----
   logic signed [PW:0] ph_x, pv_x, sum, mean, m_nxt;

   assign ph_x = $signed({p1[0][PW-1], p1[0]});
   assign pv_x = $signed({p1[1][PW-1], p1[1]});
   assign sum  = ph_x + pv_x;
   assign mean = sum >>> 1;   // arithmetic shift gives floor, -3 -> -2

   always_comb begin
      m_nxt = mean;
      case (mode1)
         2'b01:   m_nxt = ph_x;
         2'b10:   m_nxt = pv_x;
         2'b11:   m_nxt = h_gt1 ? ph_x : (v_gt1 ? pv_x : mean);
         default: m_nxt = mean;
      endcase
   end

   logic signed [PW:0] m2;
   logic [PIX_W-1:0]   green2;

   // ---- S3: subtract from green and clamp ----
   logic signed [PW+1:0] d_val;
   logic [PIX_W-1:0]     rb_nxt;
   logic                 sat_nxt;

   assign d_val = $signed({{(PW+2-PIX_W){1'b0}}, green2}) - $signed({m2[PW], m2});

   always_comb begin
      rb_nxt  = d_val[PIX_W-1:0];
      sat_nxt = 1'b0;
      if (d_val < 0) begin
         rb_nxt  = '0;
         sat_nxt = 1'b1;
      end else if (d_val > MAX_D) begin
         rb_nxt  = MAX_D[PIX_W-1:0];
         sat_nxt = 1'b1;
      end
   end

   // ---- pipeline registers; every stage holds together on stall ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         p1       <= '0;
         green1   <= '0;
         mode1    <= '0;
         h_gt1    <= 1'b0;
         v_gt1    <= 1'b0;
         m2       <= '0;
         green2   <= '0;
         rb_out   <= '0;
         sat_flag <= 1'b0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
         p1       <= p_nxt;
         green1   <= green;
         mode1    <= mode;
         h_gt1    <= scaled_h > scaled_v;
         v_gt1    <= scaled_v > scaled_h;
         m2       <= m_nxt;
         green2   <= green1;
         rb_out   <= rb_nxt;
         sat_flag <= sat_nxt;
      end
   end

`ifdef CFA_SAT_COUNT_EN
   // Counts only outputs that actually transfer. A clear wins over an
   // increment in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || sat_clr)
         sat_count <= '0;
      else if (out_valid && out_ready && sat_flag && sat_count != 16'hFFFF)
         sat_count <= sat_count + 16'd1;
   end
`endif

endmodule
